// File: rtl/fifo_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pipe_pkg
// Shared types and helpers for the FIFO + arithmetic pipeline block.
//   op_mode_t : per-token operation selector carried down the pipeline
//   apply_op  : the single arithmetic rule used by every pipeline stage
// -----------------------------------------------------------------------------
package fifo_pipe_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_RSVD = 2'd3
    } op_mode_t;

    // Widest datapath apply_op supports. Callers zero-extend their operands
    // and keep only their own low bits, which gives modulo-2^W arithmetic for
    // any W up to this value.
    localparam int OP_MAX_W = 64;

    // Reserved mode falls back to pass-through so a stray encoding cannot
    // corrupt data.
    function automatic logic [OP_MAX_W-1:0] apply_op(
        input logic [OP_MAX_W-1:0] data,
        input op_mode_t            mode,
        input logic [OP_MAX_W-1:0] step
    );
        logic [OP_MAX_W-1:0] res;
        case (mode)
            OP_ADD:  res = data + step;
            OP_SUB:  res = data - step;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fifo_pipe_stage.sv
// -----------------------------------------------------------------------------
// fifo_pipe_stage
// One register stage of the arithmetic pipeline. The token's own mode is
// applied to its data and the result is registered together with the
// valid/mode qualifiers. Invalid slots carry zero data.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_i/mode_i/data_i   token entering this stage
//   valid_o/mode_o/data_o   registered token leaving this stage
// -----------------------------------------------------------------------------
module fifo_pipe_stage
    import fifo_pipe_pkg::*;
#(
    parameter int          WIDTH = 11,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  op_mode_t         mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output op_mode_t         mode_o,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic             valid_q, valid_d;
    op_mode_t         mode_q,  mode_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] op_res;

    // Compute at full helper width, keep the low WIDTH bits (modulo wrap).
    assign op_res = WIDTH'(apply_op(OP_MAX_W'(data_i), mode_i, OP_MAX_W'(STEP_W)));

    always_comb begin
        valid_d = valid_i;
        mode_d  = mode_i;
        data_d  = valid_i ? op_res : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= OP_PASS;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fifo_pipe_alu.sv
// -----------------------------------------------------------------------------
// fifo_pipe_alu
// Circular-buffer FIFO (first-word fall-through read) feeding a never-stalled
// NUM_STAGES arithmetic pipeline. Each popped token carries the mode sampled
// in its pop cycle; every stage applies pass / +STEP / -STEP.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data
//   pop, mode       read request and operation for the token popped now
//   clr_err         synchronous clear of overflow/underflow
//   pop_data        pipeline result (zero when pop_valid=0)
//   pop_valid       pop_data holds a result
//   empty, full     occupancy flags
//   level           occupancy 0..FIFO_DEPTH
//   overflow        sticky: a push was rejected
//   underflow       sticky: a pop was rejected
// -----------------------------------------------------------------------------
module fifo_pipe_alu
    import fifo_pipe_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_WIDTH = 11,
    parameter int          NUM_STAGES = 3,
    parameter int unsigned STEP       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [FIFO_WIDTH-1:0]         push_data,
    input  logic                          pop,
    input  logic [1:0]                    mode,
    input  logic                          clr_err,
    output logic [FIFO_WIDTH-1:0]         pop_data,
    output logic                          pop_valid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Storage (not reset)
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    // Pointers carry one extra wrap bit to distinguish full from empty.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic push_acc;
    logic pop_acc;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;

    // Acceptance uses this cycle's flags only; a same-cycle pop does not make
    // room for a push, and a same-cycle push does not feed a pop.
    assign push_acc = push && !full;
    assign pop_acc  = pop  && !empty;

    always_comb begin
        wptr_d      = push_acc ? wptr_q + PW'(1) : wptr_q;
        rptr_d      = pop_acc  ? rptr_q + PW'(1) : rptr_q;
        // A new error wins over a simultaneous clear.
        overflow_d  = (push && full)  || (overflow_q  && !clr_err);
        underflow_d = (pop  && empty) || (underflow_q && !clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Pipeline: slot 0 is the fall-through head of the FIFO, slot i+1 is the
    // output of stage i.
    logic                  valid_s [NUM_STAGES+1];
    op_mode_t              mode_s  [NUM_STAGES+1];
    logic [FIFO_WIDTH-1:0] data_s  [NUM_STAGES+1];

    assign valid_s[0] = pop_acc;
    assign mode_s[0]  = op_mode_t'(mode);
    assign data_s[0]  = mem[rptr_q[AW-1:0]];

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            fifo_pipe_stage #(
                .WIDTH (FIFO_WIDTH),
                .STEP  (STEP)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .valid_i (valid_s[gi]),
                .mode_i  (mode_s[gi]),
                .data_i  (data_s[gi]),
                .valid_o (valid_s[gi+1]),
                .mode_o  (mode_s[gi+1]),
                .data_o  (data_s[gi+1])
            );
        end
    endgenerate

    assign pop_valid = valid_s[NUM_STAGES];
    assign pop_data  = data_s[NUM_STAGES];

endmodule

// File: tb/tb_fifo_pipe_alu.sv
// -----------------------------------------------------------------------------
// tb_fifo_pipe_alu
// Scoreboard bench: the driver predicts each accepted pop's result and the
// edge on which it must appear; a negedge monitor checks flags every cycle
// and pops/compares the scoreboard whenever pop_valid is seen.
// -----------------------------------------------------------------------------
module tb_fifo_pipe_alu;

    localparam int          D    = 8;
    localparam int          W    = 11;
    localparam int          N    = 3;
    localparam int unsigned STEP = 1;
    localparam int          LW   = $clog2(D) + 1;

    logic          clk;
    logic          rst;
    logic          push;
    logic [W-1:0]  push_data;
    logic          pop;
    logic [1:0]    mode;
    logic          clr_err;
    logic [W-1:0]  pop_data;
    logic          pop_valid;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    fifo_pipe_alu #(
        .FIFO_DEPTH (D),
        .FIFO_WIDTH (W),
        .NUM_STAGES (N),
        .STEP       (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .mode      (mode),
        .clr_err   (clr_err),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned  due;
        logic [W-1:0] val;
    } exp_t;

    exp_t         sb[$];    // expected outputs with the edge they are due on
    logic [W-1:0] mq[$];    // reference FIFO contents
    logic [W-1:0] obs[$];   // outputs seen, for directed literal checks
    bit           m_ovf;
    bit           m_udf;
    int unsigned  edge_cnt = 0;
    int           checks   = 0;
    int           errors   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference rule: the token is transformed N times by its own mode.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [1:0] m);
        int unsigned t;
        t = x;
        case (m)
            2'd1:    t = t + N * STEP;
            2'd2:    t = t - N * STEP;
            default: t = t;
        endcase
        return W'(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    exp_t mon_e;
    always @(negedge clk) begin
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == D);
        check("level", level, mq.size());
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
        if (pop_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", pop_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pop_data", pop_data, mon_e.val);
                check("latency", edge_cnt, mon_e.due);
                $display("out data=%03h exp=%03h edge=%0d", pop_data, mon_e.val, edge_cnt);
                obs.push_back(pop_data);
            end
        end else begin
            check("idle_data", pop_data, 0);
            if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                check("missing_valid", pop_valid, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Driver: one clock of stimulus plus reference-model update.
    task automatic cycle(input bit p, input logic [W-1:0] d, input bit q,
                         input logic [1:0] m, input bit c);
        bit   pa, pq;
        exp_t e;
        @(negedge clk);
        push = p; push_data = d; pop = q; mode = m; clr_err = c;
        pa = p && (mq.size() < D);
        pq = q && (mq.size() > 0);
        e.due = 0;
        e.val = '0;
        if (pq) begin
            e.due = edge_cnt + N;
            e.val = ref_op(mq[0], m);
        end
        @(posedge clk);
        if (pq) begin
            sb.push_back(e);
            void'(mq.pop_front());
        end
        if (pa) mq.push_back(d);
        m_ovf = (p && !pa) || (m_ovf && !c);
        m_udf = (q && !pq) || (m_udf && !c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 2'd0, 0);
    endtask

    task automatic expect_obs(input int i, input logic [W-1:0] v);
        if (obs.size() > i) check("directed_out", obs[i], v);
        else                check("directed_count", obs.size(), i + 1);
    endtask

    logic [W-1:0] vals [D];

    initial begin
        rst = 1'b1; push = 0; push_data = '0; pop = 0; mode = 2'd0; clr_err = 0;
        m_ovf = 0; m_udf = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Reset state
        #1;
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_valid", pop_valid, 0);

        // 1: push 5,6,7, pop with add
        obs.delete();
        cycle(1, 11'd5, 0, 2'd1, 0);
        cycle(1, 11'd6, 0, 2'd1, 0);
        cycle(1, 11'd7, 0, 2'd1, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 2'd1, 0);
        idle(4);
        expect_obs(0, 11'd8);
        expect_obs(1, 11'd9);
        expect_obs(2, 11'd10);
        check("t1_level", level, 0);
        check("t1_empty", empty, 1);

        // 2: fill, overflow, drain, clear
        obs.delete();
        for (int i = 0; i < D; i++) begin
            vals[i] = W'($urandom);
            cycle(1, vals[i], 0, 2'd0, 0);
        end
        check("t2_full", full, 1);
        check("t2_level", level, D);
        cycle(1, 11'h123, 0, 2'd0, 0);
        check("t2_overflow", overflow, 1);
        for (int i = 0; i < D; i++) cycle(0, '0, 1, 2'd0, 0);
        idle(4);
        for (int i = 0; i < D; i++) expect_obs(i, vals[i]);
        cycle(0, '0, 0, 2'd0, 1);
        check("t2_clr", overflow, 0);

        // 3: pop on empty with simultaneous push
        obs.delete();
        cycle(1, 11'h005, 1, 2'd0, 0);
        check("t3_underflow", underflow, 1);
        check("t3_level", level, 1);
        cycle(0, '0, 1, 2'd2, 0);
        idle(4);
        check("t3_count", obs.size(), 1);
        expect_obs(0, 11'h002);
        cycle(0, '0, 0, 2'd0, 1);

        // 4: wrap-around
        obs.delete();
        cycle(1, 11'h7FF, 0, 2'd0, 0);
        cycle(0, '0, 1, 2'd1, 0);
        cycle(1, 11'h000, 0, 2'd0, 0);
        cycle(0, '0, 1, 2'd2, 0);
        idle(4);
        expect_obs(0, 11'h002);
        expect_obs(1, 11'h7FD);

        // 5: mixed modes back-to-back
        obs.delete();
        for (int i = 0; i < 3; i++) cycle(1, 11'd10, 0, 2'd0, 0);
        cycle(0, '0, 1, 2'd0, 0);
        cycle(0, '0, 1, 2'd1, 0);
        cycle(0, '0, 1, 2'd2, 0);
        idle(4);
        expect_obs(0, 11'd10);
        expect_obs(1, 11'd13);
        expect_obs(2, 11'd7);

        // 6: reset with tokens in flight and 4 entries stored
        for (int i = 0; i < 6; i++) cycle(1, W'(20 + i), 0, 2'd0, 0);
        cycle(0, '0, 1, 2'd1, 0);
        cycle(0, '0, 1, 2'd2, 0);
        check("t6_pre_level", level, 4);
        obs.delete();
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0;
        #2 rst = 1'b1;
        #1;
        check("t6_valid", pop_valid, 0);
        check("t6_data", pop_data, 0);
        check("t6_empty", empty, 1);
        check("t6_level", level, 0);
        sb.delete(); mq.delete(); m_ovf = 0; m_udf = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        idle(6);
        check("t6_stale", obs.size(), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 2) != 0), W'($urandom),
                  bit'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 15) == 0));
        end
        idle(N + 3);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
